jellyvl_synctimer_adjust_guard: RTL
===================================

# jellyvl_synctimer_adjust_guard

Second-generation correction guard for the synchronised timer. It compares each incoming correction time against the local timer and passes small errors on as a saturated adjustment. An override request is raised only after a programmable number of consecutive out-of-window samples. It sits between the sync-packet receiver and the timer adjuster, replacing the single-shot limit check.

## Interface
- TIMER_WIDTH, 64: timer bit width.
- LIMIT_WIDTH, TIMER_WIDTH: limit and adjustment bit width, at most TIMER_WIDTH.
- COUNT_WIDTH, 4: width of the consecutive-violation threshold and counter.
- STAT_WIDTH, 32: width of the violation statistics counter.
- INIT_OVERRIDE, 1: override_request value after reset.

- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- param_limit_min  in  LIMIT_WIDTH signed  lower window bound.
- param_limit_max  in  LIMIT_WIDTH signed  upper window bound.
- param_over_count  in  COUNT_WIDTH  consecutive violations that trigger an override; 0 is treated as 1.
- current_time  in  TIMER_WIDTH  local timer.
- correct_time  in  TIMER_WIDTH  received reference time.
- correct_override  in  1  the sample is an override load.
- correct_valid  in  1  sample strobe.
- override_request  out  1  request that the next correction be an override.
- adj_diff  out  LIMIT_WIDTH signed  clamped error.
- adj_clamped  out  1  adj_diff was saturated.
- adj_valid  out  1  adj_diff strobe, single cycle.
- stat_violations  out  STAT_WIDTH  total violations; present only with the macro.

## Operation
- States:
  - TRACK: normal tracking.
  - OVERRIDE: awaiting an override load.
- Reset: state = OVERRIDE if INIT_OVERRIDE, else TRACK. Also override_request = INIT_OVERRIDE, counter = 0, adj_valid = 0, adj_clamped = 0, adj_diff = 0, stat_violations = 0, pipeline valid = 0.
- Stage 1 (on correct_valid && !correct_override):
  - Register diff = signed(correct_time − current_time), wrapping modulo 2^TIMER_WIDTH.
  - Set stage-1 valid.
- Stage 2 (stage-1 valid):
  - Sign-extend the limits to TIMER_WIDTH.
  - Violation means diff < min or diff > max. If min > max, every sample violates.
- TRACK, in-window sample: adj_valid = 1, adj_diff = diff truncated, adj_clamped = 0, counter = 0.
- TRACK, violation with counter+1 < threshold:
  - counter += 1.
  - adj_valid = 1, adj_clamped = 1.
  - adj_diff = the violated bound (min if below, max if above; max when min > max and diff > max, otherwise min).
- TRACK, violation with counter+1 ≥ threshold: go to OVERRIDE, override_request = 1, counter = 0, no adj_valid.
- OVERRIDE: stage-2 samples produce no adj_valid and do not change the counter.
- correct_valid && correct_override, in any state:
  - Go to TRACK, override_request = 0, counter = 0.
  - Clear stage-1 valid, discarding the in-flight sample.
  - Takes priority over any stage-2 result in the same cycle.
- The counter saturates at all ones.

## Timing
- correct_valid in cycle N gives adj_valid or an override_request rise in cycle N+2 (two registered stages).
- An override sample in cycle N drops override_request in cycle N+1. The stage-2 result in cycle N+1 is suppressed.
- Back-to-back samples are accepted every cycle; there is no backpressure.
- The parameter ports are sampled at stage 2 and must be quasi-static.

## Configuration
- JELLYVL_SYNCTIMER_ADJUST_GUARD_STATS_EN:
  - Defined: stat_violations counts every stage-2 violation in any state. It saturates at all ones and clears only on reset.
  - Undefined: the port is absent and no counter logic is built.

## Test plan
- Reset with INIT_OVERRIDE=1 → override_request=1. A correct_override sample at N → override_request=0 at N+1.
- Limits ±100, threshold 1, diff +50 → at N+2: adj_valid=1, adj_diff=50, adj_clamped=0.
- Threshold 3, diffs +500, +500, +500 → adj_diff=100 with adj_clamped=1 twice; third sample → override_request=1, no adj_valid.
- Diffs +500, +20, +500, +500, threshold 3 → in-window sample resets the counter, so no override request.
- current_time=2^64−10, correct_time=5 → diff=+15 in window (wrap-around).
- Violation in stage 2 coinciding with a correct_override strobe → override_request=0, state TRACK. With STATS_EN, stat_violations increments by 1.

Source files
------------

// File: rtl/jellyvl_synctimer_adjust_guard.sv
`default_nettype none
// ============================================================================
//  Module   : jellyvl_synctimer_adjust_guard
//  Function : Correction guard for the synchronised timer. Compares each
//             received correction time with the local timer, forwards small
//             errors as a saturated adjustment and raises an override request
//             after a programmable run of consecutive out-of-window samples.
//  Options  : JELLYVL_SYNCTIMER_ADJUST_GUARD_STATS_EN adds the stat_violations
//             saturating counter output.
//  Revision : 1.0  initial release
// ============================================================================
module jellyvl_synctimer_adjust_guard #(
  parameter int TIMER_WIDTH   = 64,
  parameter int LIMIT_WIDTH   = TIMER_WIDTH,
  parameter int COUNT_WIDTH   = 4,
  parameter int STAT_WIDTH    = 32,
  parameter bit INIT_OVERRIDE = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic signed [LIMIT_WIDTH-1:0]  param_limit_min,
  input  logic signed [LIMIT_WIDTH-1:0]  param_limit_max,
  input  logic        [COUNT_WIDTH-1:0]  param_over_count,
  input  logic        [TIMER_WIDTH-1:0]  current_time,
  input  logic        [TIMER_WIDTH-1:0]  correct_time,
  input  logic                           correct_override,
  input  logic                           correct_valid,
  output logic                           override_request,
  output logic signed [LIMIT_WIDTH-1:0]  adj_diff,
  output logic                           adj_clamped,
  output logic                           adj_valid
`ifdef JELLYVL_SYNCTIMER_ADJUST_GUARD_STATS_EN
  ,
  output logic        [STAT_WIDTH-1:0]   stat_violations
`endif
);

  // Elaboration-time sanity check of the width parameters.
  generate
    if (LIMIT_WIDTH > TIMER_WIDTH || LIMIT_WIDTH < 1 || COUNT_WIDTH < 1 || STAT_WIDTH < 1) begin : g_param_check
      $error("jellyvl_synctimer_adjust_guard: illegal width parameters");
    end
  endgenerate

  typedef enum logic [0:0] {
    ST_TRACK    = 1'b0,
    ST_OVERRIDE = 1'b1
  } state_t;

  state_t                          r_state;
  state_t                          w_state_next;
  logic        [COUNT_WIDTH-1:0]   r_count;
  logic        [COUNT_WIDTH-1:0]   w_count_next;
  logic                            w_req_next;
  logic                            w_adj_valid_next;
  logic signed [LIMIT_WIDTH-1:0]   w_adj_diff_next;
  logic                            w_adj_clamped_next;

  logic                            r_s1_valid;
  logic signed [TIMER_WIDTH-1:0]   r_s1_diff;

  logic                            w_ovr_strobe;
  logic signed [TIMER_WIDTH-1:0]   w_min_ext;
  logic signed [TIMER_WIDTH-1:0]   w_max_ext;
  logic                            w_below;
  logic                            w_above;
  logic                            w_inverted;
  logic                            w_violation;
  logic signed [LIMIT_WIDTH-1:0]   w_bound;
  logic        [COUNT_WIDTH-1:0]   w_thresh;
  logic        [COUNT_WIDTH:0]     w_count_inc;
  logic        [COUNT_WIDTH-1:0]   w_count_sat;

  assign w_ovr_strobe = correct_valid & correct_override;

  // Stage 1: register the wrapped error of each normal sample; an override
  // load discards whatever sample is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_diff  <= '0;
    end else if (w_ovr_strobe) begin
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= correct_valid;
      if (correct_valid) begin
        r_s1_diff <= correct_time - current_time;
      end
    end
  end

  // Window test on the stage-1 error. An inverted window (min > max) makes
  // every sample a violation; the reported bound is max only when the error
  // lies above max, otherwise min.
  assign w_min_ext   = TIMER_WIDTH'(param_limit_min);
  assign w_max_ext   = TIMER_WIDTH'(param_limit_max);
  assign w_below     = r_s1_diff < w_min_ext;
  assign w_above     = r_s1_diff > w_max_ext;
  assign w_inverted  = w_min_ext > w_max_ext;
  assign w_violation = w_below | w_above | w_inverted;
  assign w_bound     = w_above ? param_limit_max : param_limit_min;

  // A threshold of zero behaves like one: the first violation overrides.
  assign w_thresh    = (param_over_count == '0) ? COUNT_WIDTH'(1) : param_over_count;
  assign w_count_inc = {1'b0, r_count} + {{COUNT_WIDTH{1'b0}}, 1'b1};
  assign w_count_sat = (&r_count) ? r_count : w_count_inc[COUNT_WIDTH-1:0];

  // State and output register for stage 2.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= INIT_OVERRIDE ? ST_OVERRIDE : ST_TRACK;
      r_count          <= '0;
      override_request <= INIT_OVERRIDE;
      adj_valid        <= 1'b0;
      adj_diff         <= '0;
      adj_clamped      <= 1'b0;
    end else begin
      r_state          <= w_state_next;
      r_count          <= w_count_next;
      override_request <= w_req_next;
      adj_valid        <= w_adj_valid_next;
      adj_diff         <= w_adj_diff_next;
      adj_clamped      <= w_adj_clamped_next;
    end
  end

  // Next-state and output decode; an override load outranks any stage-2
  // result arriving in the same cycle.
  always_comb begin
    w_state_next       = r_state;
    w_count_next       = r_count;
    w_req_next         = override_request;
    w_adj_valid_next   = 1'b0;
    w_adj_diff_next    = adj_diff;
    w_adj_clamped_next = adj_clamped;

    if (w_ovr_strobe) begin
      w_state_next = ST_TRACK;
      w_req_next   = 1'b0;
      w_count_next = '0;
    end else if (r_s1_valid) begin
      case (r_state)
        ST_TRACK: begin
          if (!w_violation) begin
            w_adj_valid_next   = 1'b1;
            w_adj_diff_next    = LIMIT_WIDTH'(r_s1_diff);
            w_adj_clamped_next = 1'b0;
            w_count_next       = '0;
          end else if (w_count_inc < {1'b0, w_thresh}) begin
            w_count_next       = w_count_sat;
            w_adj_valid_next   = 1'b1;
            w_adj_diff_next    = w_bound;
            w_adj_clamped_next = 1'b1;
          end else begin
            w_state_next = ST_OVERRIDE;
            w_req_next   = 1'b1;
            w_count_next = '0;
          end
        end
        ST_OVERRIDE: begin
          // Waiting for an override load; normal samples are ignored.
        end
        default: begin
          w_state_next = ST_OVERRIDE;
          w_req_next   = 1'b1;
        end
      endcase
    end
  end

`ifdef JELLYVL_SYNCTIMER_ADJUST_GUARD_STATS_EN
  logic [STAT_WIDTH-1:0] r_stat;

  // Saturating count of every stage-2 violation, regardless of state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat <= '0;
    end else if (r_s1_valid && w_violation && !(&r_stat)) begin
      r_stat <= r_stat + 1'b1;
    end
  end

  assign stat_violations = r_stat;
`endif

endmodule
`default_nettype wire
